// File: rtl/sha_sched_if.sv
// Function encoding shared with the VEXU issue logic, and the bus bundle
// between the issue logic, SHA engine, vector ALU and the shared adder.
package sha_sched_pkg;
  typedef enum logic [2:0] {
    SCR1_VCRYPT_INIT = 3'd0,
    SCR1_VCRYPT_HASH = 3'd1,
    SCR1_VCRYPT_AESE = 3'd2,
    SCR1_VCRYPT_AESD = 3'd3
  } type_scr1_vcrypt_func_e;
endpackage

interface sha_sched_if;
  import sha_sched_pkg::*;

  logic                   cmd_vld;
  type_scr1_vcrypt_func_e cmd_func;
  logic                   cmd_rdy;
  logic                   done;
  logic                   err;
  logic                   sha_req;
  type_scr1_vcrypt_func_e sha_func;
  logic                   sha_rdy;
  logic [7:0][31:0]       sha_res;
  logic                   wb_vld;
  logic [7:0][31:0]       wb_data;
  logic [7:0]             wb_mask;
  logic                   valu_req;
  logic                   valu_sub;
  logic [7:0][31:0]       valu_op1;
  logic [7:0][31:0]       valu_op2;
  logic                   valu_gnt;
  logic [7:0][31:0]       valu_res;
  logic [7:0][31:0]       shaa_op1;
  logic [7:0][31:0]       shaa_op2;
  logic                   shaa_sub;
  logic [7:0][31:0]       shaa_res;
  logic [7:0][31:0]       add_op1;
  logic [7:0][31:0]       add_op2;
  logic                   add_sub;
  logic [7:0][31:0]       add_res;

  modport slave (
    input  cmd_vld, cmd_func, sha_rdy, sha_res, valu_req, valu_sub, valu_op1, valu_op2,
           shaa_op1, shaa_op2, shaa_sub, add_res,
    output cmd_rdy, done, err, sha_req, sha_func, wb_vld, wb_data, wb_mask, valu_gnt,
           valu_res, shaa_res, add_op1, add_op2, add_sub
  );

  modport master (
    output cmd_vld, cmd_func, sha_rdy, sha_res, valu_req, valu_sub, valu_op1, valu_op2,
           shaa_op1, shaa_op2, shaa_sub, add_res,
    input  cmd_rdy, done, err, sha_req, sha_func, wb_vld, wb_data, wb_mask, valu_gnt,
           valu_res, shaa_res, add_op1, add_op2, add_sub
  );
endinterface

// File: rtl/sha_sched.sv
// SHA-256 command sequencer: holds sha_req through one block compression,
// writes the digest back, and arbitrates the shared 8-lane adder.
module sha_sched #(
  parameter int HASH_CYCLES = 65,
  parameter int TIMEOUT     = 96
) (
  input  logic       clk,
  input  logic       rst_n,
  sha_sched_if.slave bus
);
  import sha_sched_pkg::*;

  typedef enum logic [1:0] {ST_IDLE, ST_INIT, ST_HASH} state_e;

  state_e           state_reg,   state_next;
  logic [6:0]       cnt_reg,     cnt_next;
  logic             done_reg,    done_next;
  logic             err_reg,     err_next;
  logic             wb_vld_reg,  wb_vld_next;
  logic [7:0]       wb_mask_reg, wb_mask_next;
  logic [7:0][31:0] wb_data_reg, wb_data_next;
  logic             sha_busy;

  if (TIMEOUT <= HASH_CYCLES) begin : g_bad_timeout
    $error("sha_sched: TIMEOUT must exceed HASH_CYCLES");
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      wb_vld_reg  <= 1'b0;
      wb_mask_reg <= '0;
      wb_data_reg <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
      wb_vld_reg  <= wb_vld_next;
      wb_mask_reg <= wb_mask_next;
      wb_data_reg <= wb_data_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    done_next    = 1'b0;
    err_next     = 1'b0;
    wb_vld_next  = 1'b0;
    wb_mask_next = '0;
    wb_data_next = wb_data_reg;
    bus.cmd_rdy  = 1'b0;
    bus.sha_req  = 1'b0;
    bus.sha_func = SCR1_VCRYPT_INIT;
    case (state_reg)
      ST_IDLE: begin
        bus.cmd_rdy = 1'b1;
        if (bus.cmd_vld) begin
          if (bus.cmd_func == SCR1_VCRYPT_INIT) begin
            state_next = ST_INIT;
          end else if (bus.cmd_func == SCR1_VCRYPT_HASH) begin
            state_next = ST_HASH;
            cnt_next   = '0;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      ST_INIT: begin
        bus.sha_req = 1'b1;
        done_next   = 1'b1;
        state_next  = ST_IDLE;
      end
      ST_HASH: begin
        bus.sha_req  = 1'b1;
        bus.sha_func = SCR1_VCRYPT_HASH;
        cnt_next     = cnt_reg + 7'd1;
        // A ready in the final allowed cycle still wins over the timeout
        if (bus.sha_rdy) begin
          wb_data_next = bus.sha_res;
          wb_mask_next = 8'hFF;
          wb_vld_next  = 1'b1;
          done_next    = 1'b1;
          state_next   = ST_IDLE;
        end else if (cnt_reg == 7'(TIMEOUT - 1)) begin
          err_next   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.done    = done_reg;
  assign bus.err     = err_reg;
  assign bus.wb_vld  = wb_vld_reg;
  assign bus.wb_mask = wb_mask_reg;
  assign bus.wb_data = wb_data_reg;

  // The SHA engine owns the adder for the whole INIT/HASH window
  assign sha_busy     = (state_reg == ST_HASH) | (state_reg == ST_INIT);
  assign bus.add_sub  = sha_busy ? bus.shaa_sub : bus.valu_sub;
  assign bus.valu_gnt = ~sha_busy & bus.valu_req;

  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    assign bus.add_op1[gi]  = sha_busy ? bus.shaa_op1[gi] : bus.valu_op1[gi];
    assign bus.add_op2[gi]  = sha_busy ? bus.shaa_op2[gi] : bus.valu_op2[gi];
    assign bus.shaa_res[gi] = bus.add_res[gi];
    assign bus.valu_res[gi] = bus.add_res[gi];
  end
endmodule

// File: tb/tb_sha_sched.sv
// Directed bench for sha_sched with a cycle-counting SHA engine stand-in
// and a behavioural 8-lane adder.
module tb_sha_sched;
  import sha_sched_pkg::*;

  localparam logic [7:0][31:0] DIGEST = {
    32'hf20015ad, 32'hb410ff61, 32'h96177a9c, 32'hb00361a3,
    32'h5dae2223, 32'h414140de, 32'h8f01cfea, 32'hba7816bf
  };

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       stuck;
  logic [6:0] stub_cnt;
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  sha_sched_if sif ();

  sha_sched #(.HASH_CYCLES(65), .TIMEOUT(96)) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (sif.slave)
  );

  // Engine stand-in: ready on the 65th HASH cycle, shares rst_n
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stub_cnt <= '0;
    else if (sif.sha_req && sif.sha_func == SCR1_VCRYPT_HASH) stub_cnt <= stub_cnt + 7'd1;
    else stub_cnt <= '0;
  end
  assign sif.sha_rdy = sif.sha_req && (sif.sha_func == SCR1_VCRYPT_HASH) &&
                       (stub_cnt == 7'd64) && !stuck;
  assign sif.sha_res = sif.sha_rdy ? DIGEST : {8{32'hdeadbeef}};

  for (genvar gi = 0; gi < 8; gi++) begin : g_add
    assign sif.add_res[gi] = sif.add_sub ? sif.add_op1[gi] - sif.add_op2[gi]
                                         : sif.add_op1[gi] + sif.add_op2[gi];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input type_scr1_vcrypt_func_e f);
    sif.cmd_vld  = 1'b1;
    sif.cmd_func = f;
    tick();
    sif.cmd_vld  = 1'b0;
    sif.cmd_func = SCR1_VCRYPT_INIT;
  endtask

  // HASH accepted at T; checks the busy window T+1..T+65 and write-back at T+66
  task automatic run_hash(input string name);
    send(SCR1_VCRYPT_HASH);
    for (int c = 1; c <= 65; c++) begin
      chk({name, "_req"},   32'(sif.sha_req), 32'd1);
      chk({name, "_func"},  32'(sif.sha_func), 32'(SCR1_VCRYPT_HASH));
      chk({name, "_gnt"},   32'(sif.valu_gnt), 32'd0);
      chk({name, "_op1"},   sif.add_op1[0], 32'h11111111);
      chk({name, "_wbv"},   32'(sif.wb_vld), 32'd0);
      if (c < 65) tick();
    end
    chk({name, "_shaa_res"}, sif.shaa_res[3], 32'h11111111 + 32'h00000022);
    tick();
    chk({name, "_wb_vld"},  32'(sif.wb_vld), 32'd1);
    chk({name, "_done"},    32'(sif.done), 32'd1);
    chk({name, "_wb0"},     sif.wb_data[0], 32'hba7816bf);
    chk({name, "_wb7"},     sif.wb_data[7], 32'hf20015ad);
    chk({name, "_mask"},    32'(sif.wb_mask), 32'hff);
    chk({name, "_rdy"},     32'(sif.cmd_rdy), 32'd1);
    chk({name, "_req_off"}, 32'(sif.sha_req), 32'd0);
    chk({name, "_gnt_back"}, 32'(sif.valu_gnt), 32'(sif.valu_req));
    tick();
    chk({name, "_wbv_clr"},  32'(sif.wb_vld), 32'd0);
    chk({name, "_mask_clr"}, 32'(sif.wb_mask), 32'd0);
    chk({name, "_done_clr"}, 32'(sif.done), 32'd0);
    $display("txn %s: HASH block written back", name);
  endtask

  initial begin
    stuck        = 1'b0;
    sif.cmd_vld  = 1'b0;
    sif.cmd_func = SCR1_VCRYPT_INIT;
    sif.valu_req = 1'b0;
    sif.valu_sub = 1'b0;
    sif.valu_op1 = {8{32'd5}};
    sif.valu_op2 = {8{32'd3}};
    sif.shaa_op1 = {8{32'h11111111}};
    sif.shaa_op2 = {8{32'h00000022}};
    sif.shaa_sub = 1'b0;

    // Reset state
    #1;
    chk("rst_req", 32'(sif.sha_req), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_cmd_rdy", 32'(sif.cmd_rdy), 32'd1);
    chk("rst_func",    32'(sif.sha_func), 32'(SCR1_VCRYPT_INIT));
    chk("rst_done",    32'(sif.done), 32'd0);
    chk("rst_err",     32'(sif.err), 32'd0);
    chk("rst_wbv",     32'(sif.wb_vld), 32'd0);
    chk("rst_wbd",     sif.wb_data[0], 32'd0);
    chk("rst_mask",    32'(sif.wb_mask), 32'd0);
    chk("rst_gnt0",    32'(sif.valu_gnt), 32'd0);
    sif.valu_req = 1'b1;
    #1;
    chk("idle_gnt",    32'(sif.valu_gnt), 32'd1);
    chk("idle_op1",    sif.add_op1[0], 32'd5);
    chk("idle_op2",    sif.add_op2[7], 32'd3);
    chk("idle_add",    sif.valu_res[2], 32'd8);
    sif.valu_sub = 1'b1;
    #1;
    chk("idle_sub",    32'(sif.add_sub), 32'd1);
    chk("idle_diff",   sif.valu_res[5], 32'd2);
    sif.valu_sub = 1'b0;
    sif.valu_req = 1'b0;
    $display("txn idle: vector ALU add/sub through shared adder");

    // INIT
    send(SCR1_VCRYPT_INIT);
    chk("init_req",  32'(sif.sha_req), 32'd1);
    chk("init_func", 32'(sif.sha_func), 32'(SCR1_VCRYPT_INIT));
    chk("init_rdy",  32'(sif.cmd_rdy), 32'd0);
    chk("init_done_early", 32'(sif.done), 32'd0);
    tick();
    chk("init_done", 32'(sif.done), 32'd1);
    chk("init_rdy2", 32'(sif.cmd_rdy), 32'd1);
    chk("init_wbv",  32'(sif.wb_vld), 32'd0);
    chk("init_req_off", 32'(sif.sha_req), 32'd0);
    tick();
    chk("init_done_clr", 32'(sif.done), 32'd0);
    $display("txn INIT: done");

    // HASH with the vector ALU requesting throughout; command and valu_req coincide in IDLE
    sif.valu_req = 1'b1;
    #1;
    chk("coinc_gnt", 32'(sif.valu_gnt), 32'd1);
    run_hash("hash1");
    sif.valu_req = 1'b0;

    // Rejected function
    send(type_scr1_vcrypt_func_e'(3'd5));
    chk("bad_err",  32'(sif.err), 32'd1);
    chk("bad_rdy",  32'(sif.cmd_rdy), 32'd1);
    chk("bad_req",  32'(sif.sha_req), 32'd0);
    tick();
    chk("bad_err_clr", 32'(sif.err), 32'd0);
    $display("txn bad func: rejected");

    // Timeout with a stuck engine
    send(SCR1_VCRYPT_INIT);
    tick();
    stuck = 1'b1;
    send(SCR1_VCRYPT_HASH);
    for (int c = 1; c <= 96; c++) begin
      chk("to_req",   32'(sif.sha_req), 32'd1);
      chk("to_early", 32'(sif.err), 32'd0);
      tick();
    end
    chk("to_err",  32'(sif.err), 32'd1);
    chk("to_wbv",  32'(sif.wb_vld), 32'd0);
    chk("to_done", 32'(sif.done), 32'd0);
    chk("to_rdy",  32'(sif.cmd_rdy), 32'd1);
    tick();
    chk("to_err_clr", 32'(sif.err), 32'd0);
    stuck = 1'b0;
    $display("txn timeout: err reported");

    // Reset in the middle of a HASH
    send(SCR1_VCRYPT_INIT);
    tick();
    send(SCR1_VCRYPT_HASH);
    repeat (30) tick();
    chk("mid_req_pre", 32'(sif.sha_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_req_async", 32'(sif.sha_req), 32'd0);
    chk("mid_rdy",       32'(sif.cmd_rdy), 32'd1);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 45; c++) begin
      chk("mid_no_done", 32'(sif.done), 32'd0);
      chk("mid_no_wbv",  32'(sif.wb_vld), 32'd0);
      tick();
    end
    $display("txn reset mid-hash: aborted");
    send(SCR1_VCRYPT_INIT);
    tick();
    run_hash("hash2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sha_sched.md
# sha_sched

Command sequencer and shared-adder arbiter for the SHA-256 engine in the vector crypto unit. It accepts INIT/HASH commands from the VEXU issue logic and holds the SHA request asserted for the full compression of one 512-bit block. It captures the digest and presents it as a VRF write-back. It also owns the single 8-lane 32-bit adder shared between the SHA engine and vector ALU add/sub operations.

## Interface
Parameters:
- HASH_CYCLES, 65, SHA cycles per block: 64 rounds plus 1 finalization.
- TIMEOUT, 96, HASH cycles after which a missing `sha_rdy` is reported as an error; must be greater than HASH_CYCLES.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_vld  in  1  command valid.
- cmd_func  in  type_scr1_vcrypt_func_e  INIT or HASH; other values are rejected.
- cmd_rdy  out  1  command accepted when `cmd_vld & cmd_rdy`.
- done  out  1  one-cycle pulse when a command completes.
- err  out  1  one-cycle pulse on timeout or rejected function.
- sha_req  out  1  request to the SHA engine.
- sha_func  out  type_scr1_vcrypt_func_e  function presented to the SHA engine.
- sha_rdy  in  1  SHA ready; high in the finalization cycle of HASH.
- sha_res  in  8x32  SHA next-state / digest.
- wb_vld  out  1  one-cycle digest write-back pulse.
- wb_data  out  8x32  captured digest.
- wb_mask  out  8  lane write enables.
- valu_req, valu_sub  in  1  vector ALU adder request and subtract select.
- valu_op1, valu_op2  in  8x32  vector ALU operands.
- valu_gnt  out  1  adder granted to the vector ALU this cycle.
- valu_res  out  8x32  adder result (valid when granted).
- shaa_op1, shaa_op2  in  8x32  SHA adder operands.
- shaa_sub  in  1  SHA adder subtract select.
- shaa_res  out  8x32  adder result returned to SHA.
- add_op1, add_op2  out  8x32  shared adder operands.
- add_sub  out  1  shared adder subtract select.
- add_res  in  8x32  shared adder result.

## Operation
- FSM states:
  - IDLE: `cmd_rdy=1`.
  - INIT: `sha_req=1`, `sha_func=INIT`; exactly one cycle, then IDLE with `done` pulse.
  - HASH: `sha_req=1`, `sha_func=HASH`; 7-bit counter `cnt` starts at 0 and increments each cycle.
- IDLE, `cmd_vld` with INIT goes to INIT; with HASH goes to HASH with `cnt` cleared.
- IDLE, `cmd_vld` with any other func: command is accepted, `err` pulses next cycle, FSM stays in IDLE.
- HASH, `sha_rdy=1`: register `sha_res` into `wb_data` and `wb_mask=8'hFF`, then go to IDLE. `wb_vld` and `done` pulse in the next cycle.
- HASH, `cnt==TIMEOUT-1` without `sha_rdy`: go to IDLE, pulse `err`, no write-back. Software must issue INIT before the next HASH.
- `sha_rdy` is ignored outside HASH.
- In INIT and IDLE, `sha_func` is driven to INIT; `sha_req=0` in IDLE.
- Adder ownership:
  - `sha_busy = (state==HASH) | (state==INIT)`.
  - When busy, `add_*` is driven from `shaa_*` and `valu_gnt=0`.
  - Otherwise, `add_*` is driven from `valu_*` and `valu_gnt=valu_req`.
  - When not busy, `add_sub` follows `valu_sub`.
- The mux is combinational. `add_res` fans out to both `shaa_res` and `valu_res` unconditionally.
- `valu_req` is not queued. The requester holds it until `valu_gnt`.
- Outputs `done`, `err`, `wb_vld` and `wb_mask` are registered. `wb_mask` is 0 except in the `wb_vld` cycle.

## Timing
- Reset values: state=IDLE, `cnt=0`, `cmd_rdy=1`, `sha_req=0`, `sha_func=INIT`, `done=0`, `err=0`, `wb_vld=0`, `wb_data=0`, `wb_mask=0`. `valu_gnt` follows `valu_req`.
- HASH accepted at cycle T:
  - `sha_req` high over T+1..T+65; `sha_rdy` expected at T+65 (`cnt=64`).
  - `wb_vld` and `done` at T+66; `cmd_rdy` is high again at T+66.
- INIT accepted at T: `sha_req` at T+1, `done` at T+2, `cmd_rdy` high at T+2.
- `cmd_vld` together with `valu_req` in IDLE: both are accepted; the vector ALU keeps the adder that cycle.
- Timeout: `err` at T+1+TIMEOUT.
- Reset asserted mid-HASH: `sha_req` drops asynchronously and no `done` or `wb_vld` is produced. The SHA engine shares `rst_n`, so its round counter clears as well.

## Test plan
- Reset then idle: every output is at its reset value; `valu_req=1` with operands 5 and 3 gives `valu_gnt=1` and `add_op1=5`, `add_op2=3`.
- INIT accepted at T: `sha_req` and `sha_func=INIT` at T+1, `done` at T+2, no `wb_vld`.
- INIT then HASH of "abc" padded block through a real SHA engine: `sha_req` high for 65 cycles; `wb_vld` one cycle later with `wb_data[0]=32'hba7816bf` and `wb_data[7]=32'hf20015ad`; `wb_mask=8'hFF`.
- `valu_req` held high during a HASH: `valu_gnt=0` for all 65 busy cycles and `add_op1` equals `shaa_op1`; `valu_gnt=1` at T+66.
- Stuck SHA (`sha_rdy` tied 0) with TIMEOUT=96: `err` pulses at T+97, no `wb_vld`, `cmd_rdy` is high again.
- Reset pulse at `cnt=30` of a HASH: `sha_req` low immediately, no `done`, and a new HASH after reset completes normally.
